uart_tx_fifo: RTL

Buffered, parametrised UART transmitter. Core logic pushes bytes through a valid/ready write port into an internal power-of-two FIFO. An internal serializer drains the FIFO onto `txd` with configurable data width, parity and stop bits. It replaces the fixed 8N1 transmit path with its fixed-size ring buffer, and adds backpressure, occupancy reporting and sticky overflow detection.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_serializer.sv | 132 +++++++++++++
 rtl/uart_tx_fifo.sv | 78 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and transmit FSM state encoding.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer: start bit, LSB-first data, optional parity, stop bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 868,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] load_data,
   output logic                 txd,
   output logic                 busy,
   output logic                 next_req
);

   localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
   localparam int unsigned IDX_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   tx_state_t            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic                 par, par_n;
   logic                 txd_n;
   logic                 tick;

   assign tick = (cnt == CNT_MAX);

   // Pop strobe: serializer idle, or finishing the final stop-bit period.
   assign next_req = (state == ST_IDLE) ||
                     ((state == ST_STOP) && tick && (idx == STOP_LAST));

   // State, bit timer, shift register and registered line outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= ST_IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         par   <= 1'b0;
         txd   <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
         par   <= par_n;
         txd   <= txd_n;
         busy  <= (state_n != ST_IDLE);
      end
   end

   // Next-state and next line level; line level follows the upcoming state.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      par_n   = par;
      txd_n   = 1'b1;

      if (state != ST_IDLE) begin
         cnt_n = tick ? '0 : cnt + 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (load) begin
               state_n = ST_START;
               cnt_n   = '0;
               sh_n    = load_data;
               par_n   = (^load_data) ^ (PARITY == PAR_ODD);
            end
         end
         ST_START: begin
            if (tick) begin
               state_n = ST_DATA;
               idx_n   = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               sh_n = sh >> 1;
               if (idx == DATA_LAST) begin
                  state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         ST_PAR: begin
            if (tick) begin
               state_n = ST_STOP;
               idx_n   = '0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (idx == STOP_LAST) begin
                  if (load) begin
                     state_n = ST_START;
                     sh_n    = load_data;
                     par_n   = (^load_data) ^ (PARITY == PAR_ODD);
                  end else begin
                     state_n = ST_IDLE;
                  end
                  idx_n = '0;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      case (state_n)
         ST_START: txd_n = 1'b0;
         ST_DATA:  txd_n = sh_n[0];
         ST_PAR:   txd_n = par_n;
         default:  txd_n = 1'b1;
      endcase
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write-port FIFO feeding the frame serializer.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 868,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = PAR_NONE,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_valid,
   input  logic [DATA_BITS-1:0]     wr_data,
   output logic                     wr_ready,
   input  logic                     clr_ovf,
   output logic                     txd,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wptr, rptr;
   logic                 push, pop, next_req;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign wr_ready = !full;
   assign push     = wr_valid && !full;
   assign pop      = next_req && !empty;

   // Pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_valid && full) overflow <= 1'b1;
         else if (clr_ovf)     overflow <= 1'b0;
      end
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

   uart_tx_serializer #(
      .CLK_PER_BIT (CLK_PER_BIT),
      .DATA_BITS   (DATA_BITS),
      .PARITY      (PARITY),
      .STOP_BITS   (STOP_BITS)
   ) u_ser (
      .clk       (clk),
      .rstn      (rstn),
      .load      (pop),
      .load_data (mem[rptr]),
      .txd       (txd),
      .busy      (busy),
      .next_req  (next_req)
   );

endmodule
